// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
//   state_e      : controller state, encoding visible on the state output
//   BCD_MAX      : wrap value for decimal digits
//   SEC_TENS_MAX : wrap value for the seconds-tens digit
//   clog2        : prescaler width helper (never returns less than 1)
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Bits needed to hold 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = v - 1; x > 0; x = x >> 1) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Keypad/control inputs and display/status outputs of the countdown timer.
//   master : keypad decoder / controller side (drives keys and commands)
//   slave  : timer side (drives digits and status)
interface bcd_countdown_timer_if #(
  parameter int unsigned MIN_DIGITS = 1
);
  logic                    key_valid;
  logic [3:0]              key_digit;
  logic                    start;
  logic                    pause;
  logic                    cancel;
  logic [3:0]              unit_secs;
  logic [3:0]              ten_secs;
  logic [4*MIN_DIGITS-1:0] minutes;
  logic                    zero;
  logic                    running;
  logic                    done;
  logic [1:0]              state;

  modport master (
    output key_valid, key_digit, start, pause, cancel,
    input  unit_secs, ten_secs, minutes, zero, running, done, state
  );

  modport slave (
    input  key_valid, key_digit, start, pause, cancel,
    output unit_secs, ten_secs, minutes, zero, running, done, state
  );
endinterface

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown: sync clear, shift-in load, decrement with wrap.
//   clk, clear_n : clock, async active-low reset
//   clr          : synchronous clear to 0 (highest priority)
//   shift_en     : load shift_in
//   dec_en       : decrement; 0 wraps to WRAP
//   q            : digit value (registered)
//   borrow_out   : decrementing from 0 this cycle
//   is_zero      : q == 0
module bcd_digit_down
  import timer_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_MAX
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       clr,
  input  logic       shift_en,
  input  logic [3:0] shift_in,
  input  logic       dec_en,
  output logic [3:0] q,
  output logic       borrow_out,
  output logic       is_zero
);

  // Digit register.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)      q <= 4'd0;
    else if (clr)      q <= 4'd0;
    else if (shift_en) q <= shift_in;
    else if (dec_en)   q <= is_zero ? WRAP : q - 4'd1;
  end

  assign is_zero    = (q == 4'd0);
  assign borrow_out = dec_en & is_zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: keypad shift-in entry, start/pause/cancel control,
// internal 1 s prescaler, one-cycle done pulse at 0:00.
//   clk, clear_n : clock, async active-low reset
//   tif (slave)  : key_valid/key_digit/start/pause/cancel in;
//                  unit_secs/ten_secs/minutes/zero/running/done/state out
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned MIN_DIGITS = 1,
  parameter int unsigned TICK_DIV   = 100
) (
  input  logic                   clk,
  input  logic                   clear_n,
  bcd_countdown_timer_if.slave   tif
);

  localparam int unsigned    PW         = clog2(TICK_DIV);
  localparam int unsigned    ND         = MIN_DIGITS + 2;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  state_e               state_q;
  logic [PW-1:0]        presc_q;
  logic [ND-1:0][3:0]   dig;        // [0]=unit secs, [1]=ten secs, [2..]=minutes LSD first
  logic [ND-1:0]        dig_zero;
  logic [ND:0]          borrow;     // borrow[i] decrements digit i
  logic                 zero_c;
  logic                 shift_en;
  logic                 tick_dec;
  logic                 last_sec;
  logic                 unused_borrow;

  assign zero_c   = &dig_zero;

  // Key entry only in IDLE and only when no higher-priority command is present.
  assign shift_en = (state_q == IDLE) & ~tif.cancel & ~tif.pause & ~tif.start &
                    tif.key_valid & (tif.key_digit <= BCD_MAX);

  // One-second decrement on the prescaler's terminal count, suppressed by pause/cancel.
  assign tick_dec = (state_q == RUN) & ~tif.cancel & ~tif.pause &
                    (presc_q == PRESC_LAST) & ~zero_c;

  // The decrement lands on 0:00 exactly when the current time is 0:01.
  assign last_sec = tick_dec & (dig[0] == 4'd1) & (&dig_zero[ND-1:1]);

  assign borrow[0] = tick_dec;
  // Top-digit borrow cannot happen since 0:00 is never decremented.
  assign unused_borrow = borrow[ND];

  for (genvar i = 0; i < ND; i++) begin : g_dig
    localparam logic [3:0] WRAP_I = (i == 1) ? SEC_TENS_MAX : BCD_MAX;
    logic [3:0] sin;
    if (i == 0) begin : g_lsd
      assign sin = tif.key_digit;
    end else begin : g_up
      assign sin = dig[i-1];
    end
    bcd_digit_down #(.WRAP(WRAP_I)) u_dig (
      .clk        (clk),
      .clear_n    (clear_n),
      .clr        (tif.cancel),
      .shift_en   (shift_en),
      .shift_in   (sin),
      .dec_en     (borrow[i]),
      .q          (dig[i]),
      .borrow_out (borrow[i+1]),
      .is_zero    (dig_zero[i])
    );
  end

  // Controller FSM and prescaler.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      presc_q <= '0;
    end else if (tif.cancel) begin
      state_q <= IDLE;
      presc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!tif.pause && tif.start && !zero_c) begin
            state_q <= RUN;
            presc_q <= '0;
          end
        end
        RUN: begin
          if (tif.pause) begin
            state_q <= PAUSE;
          end else if (presc_q == PRESC_LAST) begin
            presc_q <= '0;
            if (last_sec) state_q <= DONE;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (!tif.pause && tif.start) state_q <= RUN;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tif.unit_secs = dig[0];
  assign tif.ten_secs  = dig[1];
  assign tif.minutes   = dig[ND-1:2];
  assign tif.zero      = zero_c;
  assign tif.running   = (state_q == RUN);
  assign tif.done      = (state_q == DONE);
  assign tif.state     = state_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two instances (1 and 2 minute digits, TICK_DIV=4)
// driven by the same stimulus and compared every cycle against a digit-level model.
module tb_bcd_countdown_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       clear_n = 1'b1;
  logic       kv = 1'b0;
  logic [3:0] kd = 4'd0;
  logic       st = 1'b0, pa = 1'b0, ca = 1'b0;

  int total = 0;
  int bad   = 0;

  // Model state per instance: minutes as an integer, seconds digits, mode, prescaler.
  int m_m [2];
  int m_t [2];
  int m_u [2];
  int m_st[2];
  int m_pr[2];
  int m_lim[2] = '{10, 100};

  always #5 clk = ~clk;

  bcd_countdown_timer_if #(.MIN_DIGITS(1)) if1 ();
  bcd_countdown_timer_if #(.MIN_DIGITS(2)) if2 ();

  assign if1.key_valid = kv;
  assign if1.key_digit = kd;
  assign if1.start     = st;
  assign if1.pause     = pa;
  assign if1.cancel    = ca;
  assign if2.key_valid = kv;
  assign if2.key_digit = kd;
  assign if2.start     = st;
  assign if2.pause     = pa;
  assign if2.cancel    = ca;

  bcd_countdown_timer #(.MIN_DIGITS(1), .TICK_DIV(TD)) dut1 (
    .clk(clk), .clear_n(clear_n), .tif(if1));
  bcd_countdown_timer #(.MIN_DIGITS(2), .TICK_DIV(TD)) dut2 (
    .clk(clk), .clear_n(clear_n), .tif(if2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mzero(input int i);
    return (m_m[i] == 0) && (m_t[i] == 0) && (m_u[i] == 0);
  endfunction

  function automatic int exp_min(input int i);
    if (i == 0) return m_m[0];
    return ((m_m[1] / 10) << 4) | (m_m[1] % 10);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_m[i] = 0; m_t[i] = 0; m_u[i] = 0; m_st[i] = 0; m_pr[i] = 0;
    end
  endtask

  // One clock of behaviour, from the rules: cancel > pause > start > key.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (ca) begin
        m_m[i] = 0; m_t[i] = 0; m_u[i] = 0; m_st[i] = 0; m_pr[i] = 0;
      end else begin
        case (m_st[i])
          0: begin
            if (pa) begin
            end else if (st) begin
              if (!mzero(i)) begin m_st[i] = 1; m_pr[i] = 0; end
            end else if (kv && kd <= 4'd9) begin
              m_m[i] = (m_m[i] * 10 + m_t[i]) % m_lim[i];
              m_t[i] = m_u[i];
              m_u[i] = int'(kd);
            end
          end
          1: begin
            if (pa) m_st[i] = 2;
            else if (m_pr[i] == TD - 1) begin
              m_pr[i] = 0;
              if (m_u[i] > 0) m_u[i]--;
              else if (m_t[i] > 0) begin m_t[i]--; m_u[i] = 9; end
              else begin m_m[i]--; m_t[i] = 5; m_u[i] = 9; end
              if (mzero(i)) m_st[i] = 3;
            end else m_pr[i]++;
          end
          2: if (!pa && st) m_st[i] = 1;
          default: m_st[i] = 0;
        endcase
      end
    end
  endtask

  task automatic check_all();
    chk("u1",   32'(if1.unit_secs), 32'(m_u[0]));
    chk("t1",   32'(if1.ten_secs),  32'(m_t[0]));
    chk("m1",   32'(if1.minutes),   32'(exp_min(0)));
    chk("z1",   32'(if1.zero),      32'(mzero(0)));
    chk("run1", 32'(if1.running),   32'(m_st[0] == 1));
    chk("don1", 32'(if1.done),      32'(m_st[0] == 3));
    chk("st1",  32'(if1.state),     32'(m_st[0]));
    chk("u2",   32'(if2.unit_secs), 32'(m_u[1]));
    chk("t2",   32'(if2.ten_secs),  32'(m_t[1]));
    chk("m2",   32'(if2.minutes),   32'(exp_min(1)));
    chk("z2",   32'(if2.zero),      32'(mzero(1)));
    chk("run2", 32'(if2.running),   32'(m_st[1] == 1));
    chk("don2", 32'(if2.done),      32'(m_st[1] == 3));
    chk("st2",  32'(if2.state),     32'(m_st[1]));
  endtask

  // Drive one cycle of inputs (from a negedge), advance model, check at next negedge.
  task automatic cyc(input logic v, input logic [3:0] d, input logic s, input logic p,
                     input logic c);
    kv = v; kd = d; st = s; pa = p; ca = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    kv = 1'b0; st = 1'b0; pa = 1'b0; ca = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic key(input logic [3:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go();
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic stop();
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    clear_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_disp", 32'({if1.minutes, if1.ten_secs, if1.unit_secs}), 32'h000);
    chk("rst_done", 32'(if1.done), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  function automatic logic [11:0] disp1();
    return {if1.minutes, if1.ten_secs, if1.unit_secs};
  endfunction

  initial begin
    #1;
    async_reset();
    chk("rst_zero", 32'(if1.zero), 32'd1);

    // 1:30 -> 1:29 after one tick.
    key(4'd1); key(4'd3); key(4'd0);
    go();
    chk("t2_start", 32'(disp1()), 32'h130);
    idle(3);
    chk("t2_hold", 32'(disp1()), 32'h130);
    chk("t2_run", 32'(if1.running), 32'd1);
    idle(1);
    chk("t2_dec", 32'(disp1()), 32'h129);
    chk("t2_run2", 32'(if1.running), 32'd1);
    stop();

    // Full borrow ripple 1:00 -> 0:59.
    key(4'd1); key(4'd0); key(4'd0);
    go();
    idle(4);
    chk("t3_borrow", 32'(disp1()), 32'h059);
    stop();

    // 0:02 -> done pulse 8 cycles after start.
    key(4'd2);
    go();
    idle(7);
    chk("t4_nodone", 32'(if1.done), 32'd0);
    idle(1);
    chk("t4_done", 32'(if1.done), 32'd1);
    chk("t4_zero", 32'(if1.zero), 32'd1);
    idle(1);
    chk("t4_pulse", 32'(if1.done), 32'd0);
    chk("t4_idle", 32'(if1.state), 32'd0);

    // Pause two cycles into a tick, hold, resume.
    key(4'd5); key(4'd0);
    go();
    idle(2);
    for (int k = 0; k < 20; k++) cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("t5_frozen", 32'(disp1()), 32'h050);
    chk("t5_pause", 32'(if1.state), 32'd2);
    go();
    idle(1);
    chk("t5_wait", 32'(disp1()), 32'h050);
    idle(1);
    chk("t5_dec", 32'(disp1()), 32'h049);
    stop();

    // Ignored inputs and cancel.
    go();
    chk("t6_start0", 32'(if1.state), 32'd0);
    key(4'hA);
    chk("t6_badkey", 32'(disp1()), 32'h000);
    key(4'd1);
    go();
    key(4'd7);
    chk("t6_runkey", 32'(disp1()), 32'h001);
    idle(2);
    stop();
    chk("t6_cancel", 32'(disp1()), 32'h000);
    idle(6);
    chk("t6_nodone", 32'(if1.state), 32'd0);

    // Two minute digits: the leading 1 shifts out.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("t6_min2", 32'(if2.minutes), 32'h23);
    chk("t6_ten2", 32'(if2.ten_secs), 32'd4);
    chk("t6_unit2", 32'(if2.unit_secs), 32'd5);
    chk("t6_min1", 32'(if1.minutes), 32'h3);
    stop();

    // Async reset mid-RUN at 1:23.
    key(4'd1); key(4'd2); key(4'd3);
    go();
    idle(2);
    chk("t1_pre", 32'(disp1()), 32'h123);
    async_reset();
    chk("t1_state", 32'(if1.state), 32'd0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      logic       rv, rs, rp, rc;
      logic [3:0] rd;
      rc = ($urandom_range(0, 99) == 0);
      rp = ($urandom_range(0, 24) == 0);
      rs = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      cyc(rv, rd, rs, rp, rc);
      if ($urandom_range(0, 999) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
